// File: rtl/core_csr_pkg.sv
// core_csr_pkg: CSR addresses, trap cause codes, trap FSM states and the
// read-modify-write helper shared by the machine-mode CSR/trap logic.
package core_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;

    typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} csr_op_t;

    function automatic logic [31:0] csr_update(input csr_op_t op, input logic [31:0] old,
                                               input logic [31:0] operand);
        return op == OP_RW ? operand : op == OP_RS ? (old | operand) : (old & ~operand);
    endfunction

endpackage

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage with trap/mret side effects and the
// combinational read mux; only architecturally writable bits are stored.
module csr_regfile
    import core_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic        trap,
    input  logic [29:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] rdata,
    output logic        implemented,
    output logic        read_only,
    output logic        mie_bit,
    output logic        meie,
    output logic        mtie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic        mpie;
    logic [29:0] tvec;
    logic [29:0] epc;
    logic [31:0] scratch;
    logic [31:0] cause;

    assign mtvec     = {tvec, 2'b00};
    assign mepc      = {epc, 2'b00};
    assign read_only = addr == CSR_MIP || addr == CSR_MHARTID;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mie_bit <= 1'b0;
            mpie    <= 1'b0;
            meie    <= 1'b0;
            mtie    <= 1'b0;
            tvec    <= MTVEC_RESET[31:2];
            scratch <= '0;
            epc     <= '0;
            cause   <= '0;
        end else if (trap) begin
            epc     <= trap_pc;
            cause   <= trap_cause;
            mpie    <= mie_bit;
            mie_bit <= 1'b0;
        end else if (mret) begin
            mie_bit <= mpie;
            mpie    <= 1'b1;
        end else if (we) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_bit <= wdata[3];
                    mpie    <= wdata[7];
                end
                CSR_MIE: begin
                    meie <= wdata[11];
                    mtie <= wdata[7];
                end
                CSR_MTVEC:    tvec    <= wdata[31:2];
                CSR_MSCRATCH: scratch <= wdata;
                CSR_MEPC:     epc     <= wdata[31:2];
                CSR_MCAUSE:   cause   <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (addr)
            CSR_MSTATUS:  rdata = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_bit, 3'b0};
            CSR_MIE:      rdata = {20'b0, meie, 3'b0, mtie, 7'b0};
            CSR_MTVEC:    rdata = mtvec;
            CSR_MSCRATCH: rdata = scratch;
            CSR_MEPC:     rdata = mepc;
            CSR_MCAUSE:   rdata = cause;
            CSR_MIP:      rdata = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
            CSR_MHARTID:  rdata = HART_ID;
            default:      implemented = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: decode-stage CSR access plus machine-mode trap/mret sequencing;
// every accepted trap or mret produces a one-cycle redirect on the next cycle.
module csr_trap_unit
    import core_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [31:0] inst_pc,
    input  logic        is_csr_instr,
    input  logic        is_mret_instr,
    input  logic        is_ecall_instr,
    input  logic        csr_write,
    input  logic        csr_data_sel,
    input  logic [2:0]  func3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_field,
    input  logic [31:0] rs1_data,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
);

    state_t      state;
    csr_op_t     op;
    logic        idle;
    logic        accept;
    logic        irq_ext;
    logic        irq_pending;
    logic        take_irq;
    logic        take_trap;
    logic        take_mret;
    logic        csr_we;
    logic        implemented;
    logic        read_only;
    logic        mie_bit;
    logic        meie;
    logic        mtie;
    logic        unused_ok;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic [31:0] cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign idle        = state == S_IDLE;
    assign busy        = !idle;
    assign accept      = idle && valid;
    assign op          = csr_op_t'(func3[1:0]);
    assign irq_ext     = meie && ext_irq;
    assign irq_pending = mie_bit && (irq_ext || (mtie && timer_irq));
    assign take_irq    = accept && irq_pending;
    assign take_trap   = take_irq || (accept && is_ecall_instr);
    assign take_mret   = accept && !irq_pending && !is_ecall_instr && is_mret_instr;
    assign cause       = !take_irq ? CAUSE_ECALL : irq_ext ? CAUSE_EXT : CAUSE_TIMER;
    assign operand     = csr_data_sel ? {27'b0, rs1_field} : rs1_data;
    assign wdata       = csr_update(op, csr_rdata, operand);
    assign illegal_csr = accept && is_csr_instr && (!implemented || (read_only && csr_write));
    assign flush       = pc_redirect;
    assign unused_ok   = ^{func3[2], inst_pc[1:0]};

    // Set/clear with a zero source register is a pure read and must not write.
    assign csr_we = accept && !irq_pending && !is_ecall_instr && !is_mret_instr &&
                    is_csr_instr && csr_write && implemented && !read_only &&
                    op != OP_NONE && (op == OP_RW || rs1_field != 5'd0);

    csr_regfile #(
        .MTVEC_RESET(MTVEC_RESET),
        .HART_ID    (HART_ID)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (csr_addr),
        .we         (csr_we),
        .wdata      (wdata),
        .trap       (take_trap),
        .trap_pc    (inst_pc[31:2]),
        .trap_cause (cause),
        .mret       (take_mret),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .rdata      (csr_rdata),
        .implemented(implemented),
        .read_only  (read_only),
        .mie_bit    (mie_bit),
        .meie       (meie),
        .mtie       (mtie),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc_redirect <= 1'b0;
            redirect_pc <= '0;
        end else if (take_trap) begin
            state       <= S_TRAP;
            pc_redirect <= 1'b1;
            redirect_pc <= mtvec;
        end else if (take_mret) begin
            state       <= S_RET;
            pc_redirect <= 1'b1;
            redirect_pc <= mepc;
        end else begin
            state       <= S_IDLE;
            pc_redirect <= 1'b0;
            redirect_pc <= '0;
        end
    end

endmodule
